// File: rtl/ahb_fir_pkg.sv
// Shared bus encodings, register map, engine states and the saturation helper
// for the AHB-Lite FIR peripheral.
package ahb_fir_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Register indices are haddr[5:1].
    localparam logic [4:0] REG_STATUS     = 5'd0;
    localparam logic [4:0] REG_RESULT     = 5'd1;
    localparam logic [4:0] REG_SAMPLE     = 5'd2;
    localparam logic [4:0] REG_CTRL       = 5'd3;
    localparam logic [4:0] REG_COUNT      = 5'd4;
    localparam logic [4:0] REG_COEFF_BASE = 5'd16;

    localparam int unsigned STATUS_BUSY_BIT   = 0;
    localparam int unsigned STATUS_ERR_BIT    = 1;
    localparam int unsigned CTRL_CLR_ERR_BIT  = 0;
    localparam int unsigned CTRL_CLR_HIST_BIT = 1;

    localparam int unsigned SAT_IN_W  = 80;
    localparam int unsigned SAT_OUT_W = 64;

    typedef enum logic [1:0] {StIdle, StMac, StRound} eng_state_e;

    typedef struct packed {
        logic                 sat;
        logic [SAT_OUT_W-1:0] val;
    } sat_res_t;

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic sat_res_t saturate(input logic signed [SAT_IN_W-1:0] val,
                                          input int unsigned width);
        logic signed [SAT_IN_W-1:0] max_v;
        logic signed [SAT_IN_W-1:0] min_v;
        sat_res_t res;
        max_v   = (SAT_IN_W'(1) << (width - 1)) - SAT_IN_W'(1);
        min_v   = ~max_v;
        res.sat = 1'b0;
        res.val = val[SAT_OUT_W-1:0];
        if (val > max_v) begin
            res.sat = 1'b1;
            res.val = max_v[SAT_OUT_W-1:0];
        end else if (val < min_v) begin
            res.sat = 1'b1;
            res.val = min_v[SAT_OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_fir_filter_n_if.sv
// AHB-Lite subordinate bus bundle for the FIR peripheral.
interface ahb_fir_filter_n_if #(
    parameter int unsigned DATA_W = 16
);
    logic              hsel;
    logic [5:0]        haddr;
    logic              hsize;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hresp;

    modport master (
        output hsel, haddr, hsize, htrans, hwrite, hwdata,
        input  hrdata, hresp
    );

    modport slave (
        input  hsel, haddr, hsize, htrans, hwrite, hwdata,
        output hrdata, hresp
    );
endinterface

// File: rtl/fir_mac_engine.sv
// Sequential one-tap-per-cycle multiply-accumulate engine with rounding,
// saturation and a one-cycle result_valid pulse.
module fir_mac_engine import ahb_fir_pkg::*; #(
    parameter int unsigned NUM_TAPS = 4,
    parameter int unsigned DATA_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] coeff [NUM_TAPS],
    input  logic signed [DATA_W-1:0] hist  [NUM_TAPS],
    output logic                     busy,
    output logic                     done,
    output logic                     sat,
    output logic [DATA_W-1:0]        result,
    output logic                     result_valid
);
    localparam int unsigned TAP_W = $clog2(NUM_TAPS);
    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(NUM_TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    eng_state_e                 state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [TAP_W-1:0]           tap_q, tap_d;
    logic                       result_valid_q;
    logic signed [DATA_W-1:0]   sel_coeff, sel_hist;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    scaled;
    sat_res_t                   sat_res;
    logic [SAT_OUT_W-DATA_W-1:0] unused_sat_hi;

    always_comb begin
        sel_coeff = '0;
        sel_hist  = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (tap_q == TAP_W'(k)) begin
                sel_coeff = coeff[k];
                sel_hist  = hist[k];
            end
        end
    end

    assign prod   = (2*DATA_W)'(sel_coeff) * (2*DATA_W)'(sel_hist);
    // Arithmetic shift floors toward negative infinity.
    assign scaled = acc_q >>> (DATA_W - 1);

    always_comb begin
        sat_res       = saturate(SAT_IN_W'(scaled), DATA_W);
        result        = sat_res.val[DATA_W-1:0];
        unused_sat_hi = sat_res.val[SAT_OUT_W-1:DATA_W];
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tap_d   = tap_q;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StMac;
                    acc_d   = '0;
                    tap_d   = '0;
                end
            end
            StMac: begin
                acc_d = acc_q + ACC_W'(prod);
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == LAST_TAP) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            acc_q          <= '0;
            tap_q          <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            tap_q          <= tap_d;
            result_valid_q <= done;
        end
    end

    assign busy         = (state_q != StIdle);
    assign sat          = done && sat_res.sat;
    assign result_valid = result_valid_q;
endmodule

// File: rtl/ahb_fir_filter_n.sv
// AHB-Lite FIR peripheral: register file, coefficient RAM and sample history
// feeding a sequential MAC engine.
module ahb_fir_filter_n import ahb_fir_pkg::*; #(
    parameter int unsigned NUM_TAPS = 4,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    ahb_fir_filter_n_if.slave bus,
    output logic              busy,
    output logic              result_valid
);
    logic                     dph_valid_q, dph_write_q, dph_size_q;
    logic [5:0]               dph_addr_q;
    logic signed [DATA_W-1:0] coeff_q [NUM_TAPS];
    logic signed [DATA_W-1:0] hist_q  [NUM_TAPS];
    logic [DATA_W-1:0]        result_q, count_q, rd_data, eng_result;
    logic                     err_q, eng_done, eng_sat;
    logic [4:0]               reg_idx, coeff_off;
    logic                     is_coeff, mapped, bad, wr_ok;
    logic                     sample_we, ctrl_we, coeff_we, clr_err, clr_hist;

    assign reg_idx   = dph_addr_q[5:1];
    assign coeff_off = reg_idx - REG_COEFF_BASE;
    assign is_coeff  = (reg_idx >= REG_COEFF_BASE) && (coeff_off < 5'(NUM_TAPS));
    assign mapped    = is_coeff || (reg_idx <= REG_COUNT);

    always_comb begin
        bad = 1'b0;
        if (!mapped || dph_addr_q[0]) begin
            bad = 1'b1;
        end else if (dph_write_q) begin
            if (!dph_size_q) begin
                bad = 1'b1;
            end else if (reg_idx inside {REG_STATUS, REG_RESULT, REG_COUNT}) begin
                bad = 1'b1;
            end else if (busy && (reg_idx == REG_SAMPLE || is_coeff ||
                                  (reg_idx == REG_CTRL && bus.hwdata[CTRL_CLR_HIST_BIT]))) begin
                // History and coefficients must stay stable while the engine reads them.
                bad = 1'b1;
            end
        end
    end

    assign wr_ok     = dph_valid_q && dph_write_q && !bad;
    assign sample_we = wr_ok && (reg_idx == REG_SAMPLE);
    assign ctrl_we   = wr_ok && (reg_idx == REG_CTRL);
    assign coeff_we  = wr_ok && is_coeff;
    assign clr_err   = ctrl_we && bus.hwdata[CTRL_CLR_ERR_BIT];
    assign clr_hist  = ctrl_we && bus.hwdata[CTRL_CLR_HIST_BIT];

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            REG_STATUS: begin
                rd_data[STATUS_BUSY_BIT] = busy;
                rd_data[STATUS_ERR_BIT]  = err_q;
            end
            REG_RESULT: rd_data = result_q;
            REG_COUNT:  rd_data = count_q;
            default: begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    if (is_coeff && coeff_off == 5'(k)) begin
                        rd_data = coeff_q[k];
                    end
                end
            end
        endcase
    end

    assign bus.hrdata = (dph_valid_q && !dph_write_q && !bad) ? rd_data : '0;
    assign bus.hresp  = dph_valid_q && bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            dph_valid_q <= 1'b0;
            dph_write_q <= 1'b0;
            dph_size_q  <= 1'b0;
            dph_addr_q  <= '0;
            result_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                coeff_q[k] <= '0;
                hist_q[k]  <= '0;
            end
        end else begin
            dph_valid_q <= bus.hsel && (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
            dph_write_q <= bus.hwrite;
            dph_size_q  <= bus.hsize;
            dph_addr_q  <= bus.haddr;
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (coeff_we && coeff_off == 5'(k)) begin
                    coeff_q[k] <= bus.hwdata;
                end
            end
            if (sample_we) begin
                hist_q[0] <= bus.hwdata;
                for (int k = 1; k < NUM_TAPS; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
            end else if (clr_hist) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    hist_q[k] <= '0;
                end
            end
            if (eng_done) begin
                result_q <= eng_result;
                count_q  <= count_q + DATA_W'(1);
            end
            // A coincident saturation overrides an error clear.
            if (clr_err) begin
                err_q <= 1'b0;
            end
            if (eng_sat) begin
                err_q <= 1'b1;
            end
        end
    end

    fir_mac_engine #(
        .NUM_TAPS(NUM_TAPS),
        .DATA_W  (DATA_W)
    ) u_engine (
        .clk         (clk),
        .rst         (rst),
        .start       (sample_we),
        .coeff       (coeff_q),
        .hist        (hist_q),
        .busy        (busy),
        .done        (eng_done),
        .sat         (eng_sat),
        .result      (eng_result),
        .result_valid(result_valid)
    );
endmodule

// File: tb/tb_ahb_fir_filter_n.sv
// Randomised and directed bench for ahb_fir_filter_n against a behavioural
// model of the register map and FIR arithmetic.
module tb_ahb_fir_filter_n;
    localparam int unsigned N = 4;
    localparam int unsigned W = 16;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, result_valid;

    ahb_fir_filter_n_if #(.DATA_W(W)) bus ();

    ahb_fir_filter_n #(
        .NUM_TAPS(N),
        .DATA_W  (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic signed [15:0] m_coeff [N];
    logic signed [15:0] m_hist  [N];
    logic [15:0] m_result, m_count, pend_result;
    bit   m_err, pend_sat, valid_now, start_evt, clr_err_evt;
    bit   in_dph = 1'b0;
    int   run_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_coeff[k] = '0;
            m_hist[k]  = '0;
        end
        m_result = '0; m_count = '0; m_err = 1'b0;
        pend_result = '0; pend_sat = 1'b0;
        run_cnt = 0; valid_now = 1'b0; start_evt = 1'b0; clr_err_evt = 1'b0;
    endfunction

    // New sample enters history; result computed with plain integer arithmetic.
    function automatic void model_sample(input logic [15:0] d);
        longint s, q;
        for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = d;
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(m_coeff[k]) * longint'(m_hist[k]);
        q = s >>> 15;
        pend_sat = 1'b0;
        if (q > 32767) begin
            q = 32767; pend_sat = 1'b1;
        end else if (q < -32768) begin
            q = -32768; pend_sat = 1'b1;
        end
        pend_result = q[15:0];
        start_evt = 1'b1;
    endfunction

    function automatic bit model_err(input bit wr, input logic [5:0] a, input bit sz,
                                     input logic [15:0] wd);
        int  idx   = int'(a[5:1]);
        bit  coeff = (idx >= 16) && (idx - 16 < N);
        bit  mbusy = (run_cnt > 0);
        if (!(coeff || idx <= 4) || a[0]) return 1'b1;
        if (!wr) return 1'b0;
        if (!sz) return 1'b1;
        if (idx == 0 || idx == 1 || idx == 4) return 1'b1;
        if (mbusy && (idx == 2 || coeff || (idx == 3 && wd[1]))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] model_read(input logic [5:0] a);
        int idx = int'(a[5:1]);
        if (idx == 0) return {14'd0, m_err, run_cnt > 0};
        if (idx == 1) return m_result;
        if (idx == 4) return m_count;
        if (idx >= 16 && idx - 16 < N) return m_coeff[idx-16];
        return 16'h0000;
    endfunction

    function automatic void model_write(input logic [5:0] a, input logic [15:0] wd);
        int idx = int'(a[5:1]);
        if (idx == 2) model_sample(wd);
        else if (idx == 3) begin
            if (wd[0]) clr_err_evt = 1'b1;
            if (wd[1]) for (int k = 0; k < N; k++) m_hist[k] = '0;
        end else if (idx >= 16) m_coeff[idx-16] = wd;
    endfunction

    // Single transfer: address phase now, data phase next cycle; returns one cycle later.
    task automatic xfer(input bit wr, input logic [5:0] a, input bit sz, input logic [15:0] wd,
                        output logic [15:0] rd, output bit rs);
        bit e;
        bus.hsel = 1'b1; bus.htrans = T_NONSEQ; bus.haddr = a; bus.hwrite = wr; bus.hsize = sz;
        @(posedge clk); #1;
        bus.hsel = 1'b0; bus.htrans = T_IDLE; bus.hwrite = 1'b0; bus.hwdata = wd; in_dph = 1'b1;
        e = model_err(wr, a, sz, wd);
        rd = bus.hrdata;
        rs = bus.hresp;
        check("hresp", rs, e);
        if (!wr && !e) check("hrdata", rd, model_read(a));
        if (wr && !e) model_write(a, wd);
        @(posedge clk); #1;
        in_dph = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && run_cnt != 0; i++) begin
            @(posedge clk); #1;
        end
        check("wait_idle_bound", run_cnt, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Per-cycle comparison of busy/result_valid/hresp against the model timeline.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("busy", busy, run_cnt > 0);
            check("result_valid", result_valid, valid_now);
            if (!in_dph) check("hresp_idle", bus.hresp, 0);
            if (rst) begin
                model_reset();
            end else begin
                if (clr_err_evt) m_err = 1'b0;
                clr_err_evt = 1'b0;
                if (run_cnt == 1) begin
                    m_result = pend_result;
                    m_count  = m_count + 16'd1;
                    if (pend_sat) m_err = 1'b1;
                end
                valid_now = (run_cnt == 1);
                if (run_cnt > 0) run_cnt--;
                if (start_evt) begin
                    run_cnt   = N + 1;
                    start_evt = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        bit          rs;
        int          bc;
        bit          seen;
        logic [5:0]  addrs [12];
        addrs = '{6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h20, 6'h22, 6'h24, 6'h26,
                  6'h28, 6'h0A, 6'h21};
        bus.hsel = 1'b0; bus.htrans = T_IDLE; bus.haddr = '0; bus.hsize = 1'b1;
        bus.hwrite = 1'b0; bus.hwdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_hrdata", bus.hrdata, 0);
        xfer(0, 6'h00, 1, 0, rd, rs); check("rst_status", rd, 16'h0000); check("rst_resp", rs, 0);
        xfer(0, 6'h02, 1, 0, rd, rs); check("rst_result", rd, 16'h0000);
        xfer(0, 6'h08, 1, 0, rd, rs); check("rst_count", rd, 16'h0000);

        for (int k = 0; k < N; k++) xfer(1, 6'(6'h20 + 2 * k), 1, 16'h4000, rd, rs);
        xfer(1, 6'h04, 1, 16'h1000, rd, rs);
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) bc++;
            @(posedge clk); #1;
        end
        check("busy_len", bc, 5);
        xfer(0, 6'h02, 1, 0, rd, rs); check("res_0800", rd, 16'h0800);
        xfer(0, 6'h08, 1, 0, rd, rs); check("count_1", rd, 16'h0001);
        xfer(1, 6'h04, 1, 16'h2000, rd, rs); wait_idle();
        xfer(0, 6'h02, 1, 0, rd, rs); check("res_1800", rd, 16'h1800);
        xfer(0, 6'h08, 1, 0, rd, rs); check("count_2", rd, 16'h0002);
        xfer(1, 6'h06, 1, 16'h0002, rd, rs);
        xfer(1, 6'h04, 1, 16'h1000, rd, rs); wait_idle();
        xfer(1, 6'h04, 1, 16'hF000, rd, rs); wait_idle();
        xfer(0, 6'h02, 1, 0, rd, rs); check("res_cancel", rd, 16'h0000);
        xfer(0, 6'h01, 0, 0, rd, rs); check("odd_read_resp", rs, 1);

        for (int k = 0; k < N; k++) xfer(1, 6'(6'h20 + 2 * k), 1, 16'h7FFF, rd, rs);
        for (int i = 0; i < 4; i++) begin
            xfer(1, 6'h04, 1, 16'h7FFF, rd, rs); wait_idle();
        end
        xfer(0, 6'h02, 1, 0, rd, rs); check("res_sat", rd, 16'h7FFF);
        xfer(0, 6'h00, 0, 0, rd, rs); check("status_err", rd, 16'h0002);
        xfer(1, 6'h06, 1, 16'h0001, rd, rs);
        xfer(0, 6'h00, 1, 0, rd, rs); check("status_clr", rd, 16'h0000);

        xfer(1, 6'h04, 1, 16'h0100, rd, rs);
        xfer(1, 6'h20, 1, 16'h1111, rd, rs); check("coeff_busy_resp", rs, 1);
        wait_idle();
        xfer(0, 6'h20, 1, 0, rd, rs); check("coeff_kept", rd, 16'h7FFF);
        xfer(1, 6'h3E, 1, 16'h5555, rd, rs); check("unmapped_resp", rs, 1);
        xfer(1, 6'h20, 0, 16'h5555, rd, rs); check("byte_wr_resp", rs, 1);
        xfer(0, 6'h20, 1, 0, rd, rs); check("coeff_kept2", rd, 16'h7FFF);

        xfer(1, 6'h04, 1, 16'h0200, rd, rs);
        idle_cycles(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (result_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("rst_no_valid", seen, 0);
        xfer(0, 6'h02, 1, 0, rd, rs); check("rst_mid_result", rd, 16'h0000);
        xfer(0, 6'h20, 1, 0, rd, rs); check("rst_mid_coeff", rd, 16'h0000);

        // Pipelined write then read of COEFF[1].
        bus.hsel = 1'b1; bus.htrans = T_NONSEQ; bus.haddr = 6'h22; bus.hwrite = 1'b1;
        bus.hsize = 1'b1;
        @(posedge clk); #1;
        in_dph = 1'b1; bus.hwdata = 16'h1234;
        check("pipe_wr_resp", bus.hresp, model_err(1, 6'h22, 1, 16'h1234));
        model_write(6'h22, 16'h1234);
        bus.htrans = T_NONSEQ; bus.haddr = 6'h22; bus.hwrite = 1'b0;
        @(posedge clk); #1;
        check("pipe_rd_resp", bus.hresp, 0);
        check("pipe_rd_data", bus.hrdata, 16'h1234);
        bus.hsel = 1'b0; bus.htrans = T_IDLE;
        @(posedge clk); #1;
        in_dph = 1'b0;
        bus.hsel = 1'b1; bus.htrans = T_IDLE; bus.haddr = 6'h22; bus.hwrite = 1'b1;
        @(posedge clk); #1;
        bus.hwdata = 16'hDEAD; bus.hsel = 1'b0; bus.hwrite = 1'b0;
        check("idle_no_resp", bus.hresp, 0);
        @(posedge clk); #1;
        xfer(0, 6'h22, 1, 0, rd, rs); check("idle_no_write", rd, 16'h1234);

        for (int i = 0; i < 150; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 3) xfer(1, 6'h04, 1, 16'($urandom), rd, rs);
            else if (op <= 5) xfer(1, 6'(6'h20 + 2 * $urandom_range(0, 5)), 1, 16'($urandom), rd, rs);
            else if (op <= 7) xfer(0, addrs[$urandom_range(0, 11)], 1'($urandom), 0, rd, rs);
            else if (op == 8) xfer(1, 6'h06, 1, 16'($urandom_range(0, 3)), rd, rs);
            else xfer(1'($urandom), addrs[$urandom_range(0, 11)], 0, 16'($urandom), rd, rs);
            idle_cycles(int'($urandom_range(0, 6)));
        end
        wait_idle();
        xfer(0, 6'h02, 1, 0, rd, rs);
        xfer(0, 6'h08, 1, 0, rd, rs);
        xfer(0, 6'h00, 1, 0, rd, rs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
